spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_tick_gen.sv | 36 +++
 rtl/spi_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write-only controller and its register map.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;

    localparam logic [ADDR_W-1:0] REG_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY = 7'h04;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } spi_state_e;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {write, addr, data};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick: 8-bit down-counter, reloaded while restart is held.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || cnt_q == 8'd0) begin
            cnt_d = LOAD;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the last cycle of each D-cycle phase.
    assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame transmitter: 16-bit {write, addr, data} frames, MSB first,
// with every output registered.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              done
);

    spi_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               copi_q, copi_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               tick;

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(state_q == StIdle),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        copi_d    = copi_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d   = StSetup;
                    shift_d   = pack_frame(cmd_write, cmd_addr, cmd_data);
                    bit_cnt_d = 5'd0;
                    ncs_d     = 1'b0;
                    sclk_d    = 1'b0;
                    copi_d    = cmd_write;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                end
            end
            StShift: begin
                // sclk_q doubles as the high/low phase flag within a bit period.
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = StHold;
                        end else begin
                            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                            copi_d    = shift_q[FRAME_W-2];
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d = StGap;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= 5'd0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;
    assign done      = done_q;

endmodule
